// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one FP arithmetic unit (a/b/z strobe-ack
// handshake) among NUM_REQ requesters. One transaction at a time: operands
// are latched on grant, pushed to the unit, and the result is returned on
// a per-requester valid/ack response.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no transaction; pick next requester round-robin from rr_ptr
// S_ISSUE  | a/b strobes outstanding until each is acked by the unit
// S_WAIT_Z | both operands accepted; waiting for unit result strobe
// S_RESP   | result held on rsp_data/rsp_valid until requester acks
module fp_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ack,
  output logic [31:0]             rsp_data,
  output logic [31:0]             unit_a,
  output logic [31:0]             unit_b,
  output logic                    unit_a_stb,
  output logic                    unit_b_stb,
  input  logic                    unit_a_ack,
  input  logic                    unit_b_ack,
  input  logic [31:0]             unit_z,
  input  logic                    unit_z_stb,
  output logic                    unit_z_ack,
  output logic                    busy,
  output logic [ID_W-1:0]         cur_id
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT_Z = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      cur_id_q, cur_id_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic [31:0]          unit_a_q, unit_a_d;
  logic [31:0]          unit_b_q, unit_b_d;
  logic                 a_stb_q, a_stb_d;
  logic                 b_stb_q, b_stb_d;
  logic                 z_ack_q, z_ack_d;

  logic [31:0]          op_a_arr [NUM_REQ];
  logic [31:0]          op_b_arr [NUM_REQ];
  logic                 sel_found;
  logic [ID_W-1:0]      sel_id;
  logic [ID_W:0]        scan_sum;
  logic                 a_done;
  logic                 b_done;

  // Unpack the flat operand buses into per-requester words.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a_arr[i] = req_a[32*i +: 32];
      op_b_arr[i] = req_b[32*i +: 32];
    end
  end

  // Round-robin scan: first set req bit starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    scan_sum  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      end
      if (!sel_found && req[scan_sum[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = scan_sum[ID_W-1:0];
      end
    end
  end

  // A strobe is finished once it is low or its ack is seen with it high.
  assign a_done = !a_stb_q || unit_a_ack;
  assign b_done = !b_stb_q || unit_b_ack;

  // State register.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (a_done && b_done) state_d = S_WAIT_Z;
      end
      S_WAIT_Z: begin
        if (unit_z_stb) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ack[cur_id_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; grant and z_ack default low so they pulse.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    grant_d     = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    unit_a_d    = unit_a_q;
    unit_b_d    = unit_b_q;
    a_stb_d     = a_stb_q;
    b_stb_d     = b_stb_q;
    z_ack_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          cur_id_d         = sel_id;
          rr_ptr_d         = (sel_id == ID_W'(NUM_REQ-1)) ? '0 : sel_id + 1'b1;
          unit_a_d         = op_a_arr[sel_id];
          unit_b_d         = op_b_arr[sel_id];
          grant_d[sel_id]  = 1'b1;
          a_stb_d          = 1'b1;
          b_stb_d          = 1'b1;
        end
      end
      S_ISSUE: begin
        a_stb_d = a_stb_q && !unit_a_ack;
        b_stb_d = b_stb_q && !unit_b_ack;
      end
      S_WAIT_Z: begin
        if (unit_z_stb) begin
          rsp_data_d            = unit_z;
          z_ack_d               = 1'b1;
          rsp_valid_d[cur_id_q] = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ack[cur_id_q]) rsp_valid_d = '0;
      end
      default: ;
    endcase
  end

  // Datapath and registered-output flops.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      unit_a_q    <= '0;
      unit_b_q    <= '0;
      a_stb_q     <= 1'b0;
      b_stb_q     <= 1'b0;
      z_ack_q     <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      unit_a_q    <= unit_a_d;
      unit_b_q    <= unit_b_d;
      a_stb_q     <= a_stb_d;
      b_stb_q     <= b_stb_d;
      z_ack_q     <= z_ack_d;
    end
  end

  assign grant      = grant_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign unit_a     = unit_a_q;
  assign unit_b     = unit_b_q;
  assign unit_a_stb = a_stb_q;
  assign unit_b_stb = b_stb_q;
  assign unit_z_ack = z_ack_q;
  assign cur_id     = cur_id_q;
  assign busy       = (state_q != S_IDLE);

  // Structural invariants of the shared-unit protocol.
  a_grant_onehot: assert property (@(posedge iClk) disable iff (iRst) $onehot0(grant_q));
  a_rsp_onehot:   assert property (@(posedge iClk) disable iff (iRst) $onehot0(rsp_valid_q));
  a_zack_pulse:   assert property (@(posedge iClk) disable iff (iRst) z_ack_q |=> !z_ack_q);

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter: a behavioural FP unit (integer-valued floats,
// configurable ack/result latency) plus a round-robin reference model.
module tb_fp_unit_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic              iClk = 1'b0;
  logic              iRst;
  logic [N-1:0]      req;
  logic [N*32-1:0]   req_a;
  logic [N*32-1:0]   req_b;
  logic [N-1:0]      grant;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ack;
  logic [31:0]       rsp_data;
  logic [31:0]       unit_a;
  logic [31:0]       unit_b;
  logic              unit_a_stb;
  logic              unit_b_stb;
  logic              unit_a_ack;
  logic              unit_b_ack;
  logic [31:0]       unit_z;
  logic              unit_z_stb;
  logic              unit_z_ack;
  logic              busy;
  logic [IDW-1:0]    cur_id;

  fp_unit_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .iClk(iClk), .iRst(iRst), .req(req), .req_a(req_a), .req_b(req_b),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_data(rsp_data),
    .unit_a(unit_a), .unit_b(unit_b), .unit_a_stb(unit_a_stb), .unit_b_stb(unit_b_stb),
    .unit_a_ack(unit_a_ack), .unit_b_ack(unit_b_ack), .unit_z(unit_z),
    .unit_z_stb(unit_z_stb), .unit_z_ack(unit_z_ack), .busy(busy), .cur_id(cur_id)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_fail   = 0;
  int a_dly = 0, b_dly = 0, z_dly = 0;
  bit unit_mul = 1'b1;
  int model_rr = 0;
  logic [31:0] ops_a [N];
  logic [31:0] ops_b [N];
  logic [31:0] last_rsp;

  // Positive integer (< 2^24) to IEEE single.
  function automatic logic [31:0] to_f32(input int unsigned n);
    int e;
    logic [31:0] frac;
    e = 0;
    for (int i = 0; i < 32; i++) if (n[i]) e = i;
    frac = (n << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + e), frac[22:0]};
  endfunction

  // IEEE single holding a positive integer back to that integer.
  function automatic int unsigned from_f32(input logic [31:0] f);
    int e;
    logic [31:0] m;
    e = int'(f[30:23]) - 127;
    m = {8'h00, 1'b1, f[22:0]};
    return m >> (23 - e);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] pat, input int ptr);
    for (int k = 0; k < N; k++) if (pat[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Behavioural FP unit: acks each strobe after its delay, returns z after z_dly.
  initial begin : unit_model
    int a_cnt, b_cnt, z_cnt;
    bit got_a, got_b;
    logic [31:0] op_a, op_b;
    a_cnt = 0; b_cnt = 0; z_cnt = 0; got_a = 0; got_b = 0; op_a = '0; op_b = '0;
    unit_a_ack = 1'b0; unit_b_ack = 1'b0; unit_z_stb = 1'b0; unit_z = '0;
    forever begin
      @(negedge iClk);
      if (iRst) begin
        a_cnt = 0; b_cnt = 0; z_cnt = 0; got_a = 0; got_b = 0;
        unit_a_ack = 1'b0; unit_b_ack = 1'b0; unit_z_stb = 1'b0; unit_z = '0;
      end else begin
        unit_a_ack = 1'b0;
        unit_b_ack = 1'b0;
        if (unit_z_stb && unit_z_ack) begin
          unit_z_stb = 1'b0;
          a_cnt = 0; b_cnt = 0; z_cnt = 0; got_a = 0; got_b = 0;
        end else if (got_a && got_b && !unit_z_stb) begin
          if (z_cnt >= z_dly) begin
            unit_z_stb = 1'b1;
            unit_z = unit_mul ? to_f32(from_f32(op_a) * from_f32(op_b))
                              : to_f32(from_f32(op_a) + from_f32(op_b));
          end else z_cnt++;
        end
        if (unit_a_stb && !got_a) begin
          if (a_cnt >= a_dly) begin unit_a_ack = 1'b1; got_a = 1; op_a = unit_a; end
          else a_cnt++;
        end
        if (unit_b_stb && !got_b) begin
          if (b_cnt >= b_dly) begin unit_b_ack = 1'b1; got_b = 1; op_b = unit_b; end
          else b_cnt++;
        end
      end
    end
  end

  // Invariant watch: never more than one grant or response valid.
  always @(negedge iClk) begin
    if (iRst === 1'b0) begin
      n_checks++;
      if ($countones(grant) > 1 || $countones(rsp_valid) > 1) begin
        n_fail++;
        $display("FAIL onehot: grant=%b rsp_valid=%b, need at most one bit each", grant, rsp_valid);
      end
    end
  end

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = ops_a[i];
      req_b[32*i +: 32] = ops_b[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      ops_a[i] = to_f32($urandom_range(1, 2000));
      ops_b[i] = to_f32($urandom_range(1, 2000));
    end
  endtask

  // One full transaction. Called at a negedge with the DUT idle or in its final RESP cycle.
  task automatic do_txn(input logic [N-1:0] pat, input logic [N-1:0] keep,
                        input int ad, input int bd, input int zd, input int ackd,
                        input bit mul, input logic [N-1:0] other_ack);
    int exp_id, mx, t;
    logic [N-1:0] exp_g;
    logic [31:0] ea, eb, ed, held;
    a_dly = ad; b_dly = bd; z_dly = zd; unit_mul = mul;
    exp_id = rr_pick(pat, model_rr);
    ea = ops_a[exp_id];
    eb = ops_b[exp_id];
    ed = mul ? to_f32(from_f32(ea) * from_f32(eb)) : to_f32(from_f32(ea) + from_f32(eb));
    exp_g = '0;
    exp_g[exp_id] = 1'b1;
    mx = (ad > bd) ? ad : bd;
    drive_ops();
    req = pat;
    @(negedge iClk);
    n_checks++;
    if (grant !== exp_g) begin n_fail++; $display("FAIL grant: got %b want %b", grant, exp_g); end
    n_checks++;
    if (cur_id !== IDW'(exp_id)) begin n_fail++; $display("FAIL cur_id: got %0d want %0d", cur_id, exp_id); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_grant: got %b want 1", busy); end
    model_rr = (exp_id + 1) % N;
    req = pat & keep;
    for (int k = 0; k <= mx; k++) begin
      if (k > 0) @(negedge iClk);
      n_checks++;
      if (unit_a_stb !== (k <= ad) || unit_b_stb !== (k <= bd)) begin
        n_fail++;
        $display("FAIL strobes k=%0d: got a=%b b=%b want a=%b b=%b", k, unit_a_stb, unit_b_stb, k <= ad, k <= bd);
      end
      n_checks++;
      if (unit_a !== ea || unit_b !== eb) begin
        n_fail++;
        $display("FAIL operands k=%0d: got %h %h want %h %h", k, unit_a, unit_b, ea, eb);
      end
    end
    @(negedge iClk);
    n_checks++;
    if (unit_a_stb !== 1'b0 || unit_b_stb !== 1'b0 || grant !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL post_issue: stb_a=%b stb_b=%b grant=%b busy=%b want 0 0 0000 1",
               unit_a_stb, unit_b_stb, grant, busy);
    end
    t = 0;
    while (rsp_valid === '0 && t < 64) begin @(negedge iClk); t++; end
    n_checks++;
    if (t >= 64) begin
      n_fail++;
      $display("FAIL rsp_timeout: rsp_valid=%b after 64 cycles, want %b", rsp_valid, exp_g);
      req = '0;
      return;
    end
    if (zd == 0) begin
      n_checks++;
      if (t != 1) begin n_fail++; $display("FAIL rsp_latency: got %0d cycles want 1", t); end
    end
    n_checks++;
    if (rsp_valid !== exp_g || rsp_data !== ed) begin
      n_fail++;
      $display("FAIL response: got valid=%b data=%h want %b %h", rsp_valid, rsp_data, exp_g, ed);
    end
    n_checks++;
    if (unit_z_ack !== 1'b1) begin n_fail++; $display("FAIL z_ack_pulse: got %b want 1", unit_z_ack); end
    held = rsp_data;
    last_rsp = rsp_data;
    rsp_ack = other_ack & ~exp_g;
    for (int s = 0; s < ackd; s++) begin
      @(negedge iClk);
      n_checks++;
      if (rsp_valid !== exp_g || rsp_data !== held || grant !== '0 || unit_z_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL stall s=%0d: valid=%b data=%h grant=%b zack=%b want %b %h 0000 0",
                 s, rsp_valid, rsp_data, grant, unit_z_ack, exp_g, held);
      end
    end
    rsp_ack = other_ack | exp_g;
    @(negedge iClk);
    n_checks++;
    if (rsp_valid !== '0 || unit_z_ack !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release: valid=%b zack=%b busy=%b want 0000 0 0", rsp_valid, unit_z_ack, busy);
    end
    rsp_ack = '0;
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (grant !== '0 || rsp_valid !== '0 || unit_a_stb !== 1'b0 || unit_b_stb !== 1'b0 ||
        unit_z_ack !== 1'b0 || busy !== 1'b0 || cur_id !== '0) begin
      n_fail++;
      $display("FAIL %s ctrl: grant=%b rv=%b sa=%b sb=%b zack=%b busy=%b id=%0d want all 0",
               tag, grant, rsp_valid, unit_a_stb, unit_b_stb, unit_z_ack, busy, cur_id);
    end
    n_checks++;
    if (rsp_data !== '0 || unit_a !== '0 || unit_b !== '0) begin
      n_fail++;
      $display("FAIL %s data: rsp=%h a=%h b=%h want 0", tag, rsp_data, unit_a, unit_b);
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1; req = '0; rsp_ack = '0; req_a = '0; req_b = '0;
    @(negedge iClk);
    @(negedge iClk);
    check_reset_values("reset");
    iRst = 1'b0;
    model_rr = 0;
  endtask

  task automatic test_fairness();
    rand_ops();
    for (int i = 0; i < 5; i++) do_txn(4'b1111, 4'b1111, 0, 0, 0, 0, 1'b1, 4'b0000);
    req = '0;
  endtask

  task automatic test_single_request();
    ops_a[0] = 32'h4000_0000;
    ops_b[0] = 32'h4040_0000;
    do_txn(4'b0001, 4'b0000, 0, 0, 2, 0, 1'b1, 4'b0000);
    n_checks++;
    if (last_rsp !== 32'h40C0_0000) begin n_fail++; $display("FAIL single_mul: got %h want 40c00000", last_rsp); end
  endtask

  task automatic test_ack_ordering();
    rand_ops();
    do_txn(4'b0010, 4'b0000, 2, 0, 0, 0, 1'b1, 4'b0000);
    do_txn(4'b0100, 4'b0000, 1, 1, 0, 1, 1'b1, 4'b0000);
    do_txn(4'b1000, 4'b0000, 0, 3, 1, 0, 1'b0, 4'b0000);
  endtask

  task automatic test_response_stall();
    rand_ops();
    model_rr = model_rr;
    do_txn(4'b0101, 4'b0001, 0, 0, 0, 10, 1'b1, 4'b1011);
    do_txn(4'b0001, 4'b0000, 0, 0, 0, 0, 1'b1, 4'b0000);
  endtask

  task automatic test_reset_mid_op();
    rand_ops();
    drive_ops();
    a_dly = 0; b_dly = 0; z_dly = 30; unit_mul = 1'b1;
    req = 4'b0100;
    @(negedge iClk);
    n_checks++;
    if (grant !== 4'b0100) begin n_fail++; $display("FAIL midop_grant: got %b want 0100", grant); end
    req = '0;
    repeat (4) @(negedge iClk);
    n_checks++;
    if (busy !== 1'b1 || unit_a_stb !== 1'b0 || unit_b_stb !== 1'b0 || rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL midop_waitz: busy=%b sa=%b sb=%b rv=%b want 1 0 0 0000", busy, unit_a_stb, unit_b_stb, rsp_valid);
    end
    iRst = 1'b1;
    @(negedge iClk);
    check_reset_values("midop_reset");
    @(negedge iClk);
    iRst = 1'b0;
    model_rr = 0;
    rand_ops();
    do_txn(4'b1010, 4'b0000, 0, 0, 0, 0, 1'b1, 4'b0000);
    do_txn(4'b0010, 4'b0000, 1, 0, 1, 1, 1'b1, 4'b0000);
  endtask

  task automatic test_adder();
    ops_a[3] = 32'h3F80_0000;
    ops_b[3] = 32'h4000_0000;
    do_txn(4'b1000, 4'b0000, 1, 1, 0, 2, 1'b0, 4'b0000);
    n_checks++;
    if (last_rsp !== 32'h4040_0000) begin n_fail++; $display("FAIL adder: got %h want 40400000", last_rsp); end
  endtask

  task automatic test_random();
    logic [N-1:0] pat, keep, oth;
    for (int it = 0; it < 40; it++) begin
      rand_ops();
      pat  = N'($urandom_range(1, (1 << N) - 1));
      keep = N'($urandom);
      oth  = N'($urandom);
      do_txn(pat, keep, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
             $urandom_range(0, 4), 1'($urandom), oth);
    end
    req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fairness();
    test_single_request();
    test_response_stall();
    test_ack_ordering();
    test_adder();
    test_reset_mid_op();
    test_random();
    repeat (3) @(negedge iClk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
